// File: rtl/and4_core.sv
`default_nettype none
`timescale 1ns/1ps
// and4_core: bitwise four-input AND of WIDTH-bit operands, purely combinational.
module and4_core #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] y
);

    assign y = a & b & c & d;

endmodule
`default_nettype wire

// File: rtl/and4.sv
`default_nettype none
`timescale 1ns/1ps
// and4: four-input AND with registered copy, all-ones flag, rising-edge pulse
// and a saturating count of cycles in which every output bit was high.
module and4 #(
    parameter int WIDTH   = 1,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   c,
    input  logic [WIDTH-1:0]   d,
    output logic [WIDTH-1:0]   out,
    output logic [WIDTH-1:0]   out_q,
    output logic               all_q,
    output logic               rise,
    output logic [COUNT_W-1:0] hit_cnt
);

    logic all_now;

    and4_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a (a),
        .b (b),
        .c (c),
        .d (d),
        .y (out)
    );

    assign all_now = &out;

    // all_q doubles as the history bit for the rising-edge detector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            all_q   <= 1'b0;
            rise    <= 1'b0;
            hit_cnt <= '0;
        end else begin
            out_q <= out;
            all_q <= all_now;
            rise  <= all_now & ~all_q;
            if (all_now && (hit_cnt != {COUNT_W{1'b1}})) begin
                hit_cnt <= hit_cnt + COUNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_and4.sv
`default_nettype none
`timescale 1ns/1ps
// tb_and4: scoreboard-based bench for and4 across WIDTH=1, COUNT_W=2 and WIDTH=4 instances.
module tb_and4;

    logic       clk;
    logic       rst1_n, rst2_n, rst4_n;

    logic       a1, b1, c1, d1, out1, out_q1, all_q1, rise1;
    logic [7:0] hit1;
    logic       a2, b2, c2, d2, out2, out_q2, all_q2, rise2;
    logic [1:0] hit2;
    logic [3:0] a4, b4, c4, d4, out4, out_q4;
    logic       all_q4, rise4;
    logic [7:0] hit4;

    and4 #(.WIDTH(1), .COUNT_W(8)) u_and4_w1 (
        .clk(clk), .rst_n(rst1_n), .a(a1), .b(b1), .c(c1), .d(d1),
        .out(out1), .out_q(out_q1), .all_q(all_q1), .rise(rise1), .hit_cnt(hit1)
    );

    and4 #(.WIDTH(1), .COUNT_W(2)) u_and4_sat (
        .clk(clk), .rst_n(rst2_n), .a(a2), .b(b2), .c(c2), .d(d2),
        .out(out2), .out_q(out_q2), .all_q(all_q2), .rise(rise2), .hit_cnt(hit2)
    );

    and4 #(.WIDTH(4), .COUNT_W(8)) u_and4_w4 (
        .clk(clk), .rst_n(rst4_n), .a(a4), .b(b4), .c(c4), .d(d4),
        .out(out4), .out_q(out_q4), .all_q(all_q4), .rise(rise4), .hit_cnt(hit4)
    );

    // Rising edges at 1.5, 3.5, ... so integer-time input toggles never race the clock.
    initial begin
        clk = 1'b1;
        #0.5;
        forever #1 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;
    sb_t sb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $realtime);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic sb_pop(input logic [31:0] got);
        sb_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_empty: got %0h expected none", got);
        end else begin
            e = sb.pop_front();
            check(e.tag, got, e.exp);
        end
    endtask

    // Toggling stimulus yields a&b&c&d high only in [35,36) and [39,40).
    function automatic logic in_win(input real t);
        return ((t >= 35.0) && (t < 36.0)) || ((t >= 39.0) && (t < 40.0));
    endfunction

    typedef struct {
        logic [3:0] a, b, c, d;
        logic [3:0] e_out;
        logic       e_all, e_rise;
        logic [7:0] e_hit;
    } vec4_t;

    initial begin
        #5000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vec4_t v4[4];
        rst1_n = 1'b0; rst2_n = 1'b0; rst4_n = 1'b0;
        {a1, b1, c1, d1} = 4'h0;
        {a2, b2, c2, d2} = 4'h0;
        a4 = '0; b4 = '0; c4 = '0; d4 = '0;

        fork
            begin : stim
                for (int t = 1; t <= 70; t++) begin
                    #1;
                    if (t % 10 == 0) a1 = ~a1;
                    if (t % 7  == 0) b1 = ~b1;
                    if (t % 5  == 0) c1 = ~c1;
                    if (t % 3  == 0) d1 = ~d1;
                end
            end
            begin : rst_seq
                #0.25;
                check("rst_out_q", 32'(out_q1), 32'd0);
                check("rst_all_q", 32'(all_q1), 32'd0);
                check("rst_rise",  32'(rise1),  32'd0);
                check("rst_hit",   32'(hit1),   32'd0);
                #0.75;
                rst1_n = 1'b1; rst2_n = 1'b1; rst4_n = 1'b1;
            end
            begin : comb_chk
                #0.25;
                for (int k = 0; k < 70; k++) begin
                    check("tog_out", 32'(out1), 32'(in_win(real'(k) + 0.25)));
                    #1;
                end
            end
            begin : reg_chk
                logic       w;
                logic       prev_all;
                int         exp_hit;
                prev_all = 1'b0;
                exp_hit  = 0;
                repeat (35) begin
                    @(posedge clk);
                    w = in_win($realtime);
                    if (w) exp_hit++;
                    sb_push("tog_out_q", 32'(w));
                    sb_push("tog_all_q", 32'(w));
                    sb_push("tog_rise",  32'(w & ~prev_all));
                    sb_push("tog_hit",   32'(exp_hit));
                    prev_all = w;
                    @(negedge clk);
                    sb_pop(32'(out_q1));
                    sb_pop(32'(all_q1));
                    sb_pop(32'(rise1));
                    sb_pop(32'(hit1));
                end
            end
        join

        for (int i = 0; i < 16; i++) begin
            {a1, b1, c1, d1} = 4'(i);
            #0.1;
            check("tt_out", 32'(out1), 32'(i == 15));
        end

        @(negedge clk);
        {a2, b2, c2, d2} = 4'hF;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            sb_push("sat_hit",  (i + 1 > 3) ? 32'd3 : 32'(i + 1));
            sb_push("sat_rise", 32'(i == 0));
            @(negedge clk);
            sb_pop(32'(hit2));
            sb_pop(32'(rise2));
        end

        #0.3;
        rst2_n = 1'b0;
        #0.1;
        check("arst_hit",   32'(hit2),   32'd0);
        check("arst_out_q", 32'(out_q2), 32'd0);
        check("arst_all_q", 32'(all_q2), 32'd0);
        check("arst_rise",  32'(rise2),  32'd0);
        check("arst_out",   32'(out2),   32'd1);
        d2 = 1'b0;
        #0.1;
        check("arst_out_track", 32'(out2), 32'd0);
        d2 = 1'b1;
        @(negedge clk);
        rst2_n = 1'b1;
        @(posedge clk);
        #0.2;
        check("rel_rise",  32'(rise2),  32'd1);
        check("rel_hit",   32'(hit2),   32'd1);
        check("rel_all_q", 32'(all_q2), 32'd1);
        @(posedge clk);
        #0.2;
        check("rel_rise2", 32'(rise2), 32'd0);
        check("rel_hit2",  32'(hit2),  32'd2);

        v4[0] = '{a:4'hF, b:4'hA, c:4'hE, d:4'hB, e_out:4'hA, e_all:1'b0, e_rise:1'b0, e_hit:8'd0};
        v4[1] = '{a:4'hF, b:4'hF, c:4'hF, d:4'hF, e_out:4'hF, e_all:1'b1, e_rise:1'b1, e_hit:8'd1};
        v4[2] = '{a:4'hF, b:4'hF, c:4'hF, d:4'hF, e_out:4'hF, e_all:1'b1, e_rise:1'b0, e_hit:8'd2};
        v4[3] = '{a:4'h7, b:4'hF, c:4'h5, d:4'hC, e_out:4'h4, e_all:1'b0, e_rise:1'b0, e_hit:8'd2};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a4 = v4[i].a; b4 = v4[i].b; c4 = v4[i].c; d4 = v4[i].d;
            #0.1;
            check("w4_out", 32'(out4), 32'(v4[i].e_out));
            sb_push("w4_out_q", 32'(v4[i].e_out));
            sb_push("w4_all_q", 32'(v4[i].e_all));
            sb_push("w4_rise",  32'(v4[i].e_rise));
            sb_push("w4_hit",   32'(v4[i].e_hit));
            @(posedge clk);
            #0.2;
            sb_pop(32'(out_q4));
            sb_pop(32'(all_q4));
            sb_pop(32'(rise4));
            sb_pop(32'(hit4));
        end

        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_leftover: got %0d entries expected 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
